// File: rtl/decel_pkg.sv
// Shared types and helpers for the deceleration classifier: sensitivity
// encoding, per-stage threshold and thermometer encoding.
package decel_pkg;

    typedef enum logic [1:0] {
        SEN_LOW  = 2'b00,
        SEN_MED  = 2'b01,
        SEN_HIGH = 2'b10,
        SEN_OFF  = 2'b11
    } sen_t;

    // Widest stage vector the thermometer helper supports.
    localparam int MAX_STAGES = 8;

    // Stage-k threshold for a sensitivity. SEN_OFF yields 0; the level is forced
    // to 0 in that mode, so the value never reaches an output.
    function automatic int th(input sen_t sen, input int k,
                              input int base_low, input int base_med, input int base_high,
                              input int step_low, input int step_med, input int step_high);
        int r;
        case (sen)
            SEN_LOW:  r = base_low  + k * step_low;
            SEN_MED:  r = base_med  + k * step_med;
            SEN_HIGH: r = base_high + k * step_high;
            default:  r = 0;
        endcase
        return r;
    endfunction

    // Thermometer code: bit i set iff level > i.
    function automatic logic [MAX_STAGES-1:0] therm(input int level);
        logic [MAX_STAGES-1:0] t;
        for (int i = 0; i < MAX_STAGES; i++) t[i] = (level > i);
        return t;
    endfunction

endpackage

// File: rtl/sample_debounce.sv
// Per-lane sample-count debounce: a lane's output follows its input only after
// DEPTH consecutive valid samples disagree with the current output.
module sample_debounce #(
    parameter int N     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] cnt [N];

    // Count consecutive disagreeing samples per lane; an agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
            // NOTE: this counter array is a handful of flops, not a RAM, so it is reset like any other state.
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (valid) begin
            for (int i = 0; i < N; i++) begin
                if (in[i] == out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEPTH - 1)) begin
                    out[i] <= in[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/decel_classifier_gen2.sv
// Deceleration classifier: maps Z samples to a debounced, hysteretic, held
// brake-light level with stale-sample supervision; X samples drive tipover.
module decel_classifier_gen2
    import decel_pkg::*;
#(
    parameter int DATA_W           = 14,
    parameter int NUM_STAGES       = 2,
    parameter int TH_BASE_LOW      = 1025,
    parameter int TH_BASE_MED      = 820,
    parameter int TH_BASE_HIGH     = 615,
    parameter int TH_STEP_LOW      = 820,
    parameter int TH_STEP_MED      = 615,
    parameter int TH_STEP_HIGH     = 410,
    parameter int MAX_G            = 4000,
    parameter int HYST             = 41,
    parameter int DEBOUNCE_SAMPLES = 125,
    parameter int MIN_HOLD_CYCLES  = 1560000,
    parameter int TIMEOUT_CYCLES   = 20800,
    parameter int TIP_LO           = 3300,
    parameter int TIP_HI           = 13084,
    parameter int TIP_DEBOUNCE     = 50
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] z_data,
    input  logic                     z_valid,
    input  logic signed [DATA_W-1:0] x_data,
    input  logic                     x_valid,
    input  logic [1:0]               sen_setting,
    input  logic                     test,
    output logic [NUM_STAGES-1:0]    stage_out,
    output logic                     any_active,
    output logic                     stale,
    output logic                     tipover
);
    localparam int TH_W   = DATA_W + $clog2(NUM_STAGES) + 2;
    localparam int LVL_W  = $clog2(NUM_STAGES + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam int HOLD_W = $clog2(MIN_HOLD_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    sen_t                   sen, sen_q;
    logic signed [TH_W-1:0] z_ext, th_k;
    logic [LVL_W-1:0]       raw_level, cur_level, cand_level, cand_next, last_raw, drop_src;
    logic [DB_W-1:0]        cand_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [TO_W-1:0]        timeout_cnt;
    logic [NUM_STAGES-1:0]  byp_q;
    logic                   expire, mode_clear, in_window;
    int                     x_val;

    assign sen        = sen_t'(sen_setting);
    assign z_ext      = TH_W'(z_data);
    assign mode_clear = (sen == SEN_OFF) || (sen != sen_q);
    assign expire     = !z_valid && (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Raw level: count of thresholds met, with hysteresis on stages already lit.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
        raw_level = '0;
        th_k      = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            th_k = TH_W'(th(sen, k, TH_BASE_LOW, TH_BASE_MED, TH_BASE_HIGH,
                            TH_STEP_LOW, TH_STEP_MED, TH_STEP_HIGH));
            if (k < int'(cur_level)) th_k = th_k - TH_W'(HYST);
            if (z_ext >= th_k) raw_level = raw_level + LVL_W'(1);
        end
        if (z_data[DATA_W-1] || z_ext >= TH_W'(MAX_G)) raw_level = '0;
    end

    // Candidate tracks the minimum qualifying level; drops use the freshest raw level.
    always_comb begin
        cand_next = (cand_cnt == '0 || raw_level < cand_level) ? raw_level : cand_level;
        drop_src  = z_valid ? raw_level : last_raw;
    end

    // Filtered level state: rise debounce, hold, drop, timeout and mode clears.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sen_q      <= SEN_LOW;
            cur_level  <= '0;
            cand_level <= '0;
            cand_cnt   <= '0;
            hold_cnt   <= '0;
            last_raw   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
            sen_q <= sen;
            if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
            if (z_valid) last_raw <= raw_level;
            if (mode_clear || expire) begin
                cur_level  <= '0;
                cand_level <= '0;
                cand_cnt   <= '0;
                hold_cnt   <= '0;
            end else begin
                if (z_valid) begin
                    if (raw_level > cur_level) begin
                        if (cand_cnt == DB_W'(DEBOUNCE_SAMPLES - 1)) begin
                            cur_level  <= cand_next;
                            hold_cnt   <= HOLD_W'(MIN_HOLD_CYCLES);
                            cand_cnt   <= '0;
                            cand_level <= '0;
                        end else begin
                            cand_cnt   <= cand_cnt + DB_W'(1);
                            cand_level <= cand_next;
                        end
                    end else begin
                        cand_cnt   <= '0;
                        cand_level <= '0;
                    end
                end
                if (hold_cnt == '0 && drop_src < cur_level) cur_level <= drop_src;
            end
        end
    end

    // Stale supervision: count idle cycles, flag stale once the budget is used up.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
            stale       <= 1'b1;
        end else if (z_valid) begin
            timeout_cnt <= '0;
            stale       <= 1'b0;
        end else if (timeout_cnt != TO_W'(TIMEOUT_CYCLES)) begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
            if (expire) stale <= 1'b1;
        end
    end

    // Bypass register: unfiltered thermometer of each raw sample, forced off by mode clears.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q <= '0;
        end else if (mode_clear) begin
            byp_q <= '0;
        end else if (z_valid) begin
            byp_q <= NUM_STAGES'(therm(int'(raw_level)));
        end
    end

    assign stage_out  = test ? byp_q : NUM_STAGES'(therm(int'(cur_level)));
    assign any_active = |stage_out;

    assign x_val     = int'(x_data);
    assign in_window = (x_val >= TIP_LO) && (x_val < TIP_HI);

    sample_debounce #(
        .N     (1),
        .DEPTH (TIP_DEBOUNCE)
    ) u_tip_debounce (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .valid (x_valid),
        .in    (in_window),
        .out   (tipover)
    );

endmodule

// File: tb/tb_decel_classifier_gen2.sv
// Self-checking bench for decel_classifier_gen2: a cycle model built from the
// level/hold/timeout/tipover rules, compared every cycle, plus directed literals.
module tb_decel_classifier_gen2;

    localparam int DEB   = 3;
    localparam int HOLD  = 20;
    localparam int TOUT  = 50;
    localparam int TIPD  = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [13:0] z_data, x_data;
    logic               z_valid, x_valid, test;
    logic [1:0]         sen_setting;
    logic [1:0]         stage_out;
    logic               any_active, stale, tipover;

    int n_tests = 0;
    int n_fail  = 0;

    decel_classifier_gen2 #(
        .DEBOUNCE_SAMPLES (DEB),
        .MIN_HOLD_CYCLES  (HOLD),
        .TIMEOUT_CYCLES   (TOUT),
        .TIP_DEBOUNCE     (TIPD)
    ) dut (
        .sys_clk     (clk),
        .rst_n       (rst_n),
        .z_data      (z_data),
        .z_valid     (z_valid),
        .x_data      (x_data),
        .x_valid     (x_valid),
        .sen_setting (sen_setting),
        .test        (test),
        .stage_out   (stage_out),
        .any_active  (any_active),
        .stale       (stale),
        .tipover     (tipover)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_level, m_byp, m_last_raw, m_idle, m_rise_cyc, m_sen_prev, m_cyc;
    bit  m_stale, m_tip;
    int  cand_q[$];
    bit  x_hist[$];

    function automatic int model_raw(input int z, input int sen, input int level);
        int base[3] = '{1025, 820, 615};
        int step[3] = '{820, 615, 410};
        int n = 0;
        if (sen == 3 || z < 0 || z >= 4000) return 0;
        for (int k = 0; k < 2; k++) begin
            int thr;
            thr = base[sen] + k * step[sen] - ((k < level) ? 41 : 0);
            if (z >= thr) n++;
        end
        return n;
    endfunction

    function automatic logic [1:0] therm2(input int lvl);
        return 2'((1 << lvl) - 1);
    endfunction

    always @(posedge clk) begin
        int  raw, mn, xv;
        bit  expire, clr, win, flip;
        if (!rst_n) begin
            m_level = 0; m_byp = 0; m_last_raw = 0; m_idle = 0;
            m_rise_cyc = -1000; m_sen_prev = 0; m_cyc = 0;
            m_stale = 1; m_tip = 0;
            cand_q.delete();
            x_hist.delete();
        end else begin
            m_cyc++;
            raw    = model_raw(int'(z_data), int'(sen_setting), m_level);
            expire = 0;
            if (z_valid) begin
                m_last_raw = raw;
                m_idle     = 0;
                m_stale    = 0;
            end else begin
                m_idle++;
                if (m_idle == TOUT) begin
                    expire  = 1;
                    m_stale = 1;
                end
            end
            clr = (sen_setting == 2'b11) || (int'(sen_setting) != m_sen_prev);
            m_sen_prev = int'(sen_setting);
            if (clr) m_byp = 0;
            else if (z_valid) m_byp = raw;
            if (clr || expire) begin
                m_level = 0;
                cand_q.delete();
                m_rise_cyc = -1000;
            end else begin
                if (z_valid) begin
                    if (raw > m_level) begin
                        cand_q.push_back(raw);
                        if (cand_q.size() == DEB) begin
                            mn = cand_q[0];
                            foreach (cand_q[i]) if (cand_q[i] < mn) mn = cand_q[i];
                            m_level    = mn;
                            m_rise_cyc = m_cyc;
                            cand_q.delete();
                        end
                    end else begin
                        cand_q.delete();
                    end
                end
                if ((m_cyc - m_rise_cyc) > HOLD && m_last_raw < m_level) m_level = m_last_raw;
            end
            if (x_valid) begin
                xv  = int'(x_data);
                win = (xv >= 3300) && (xv < 13084);
                x_hist.push_back(win);
                if (x_hist.size() > TIPD) void'(x_hist.pop_front());
                flip = (x_hist.size() == TIPD);
                foreach (x_hist[i]) if (x_hist[i] == m_tip) flip = 0;
                if (flip) m_tip = !m_tip;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int exp_lvl;
        if (rst_n === 1'b1) begin
            exp_lvl = test ? m_byp : m_level;
            check("cyc_stage", 32'(stage_out), 32'(therm2(exp_lvl)));
            check("cyc_any", 32'(any_active), 32'(exp_lvl > 0));
            check("cyc_stale", 32'(stale), 32'(m_stale));
            check("cyc_tip", 32'(tipover), 32'(m_tip));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic z_pulse(input int v);
        z_data  = 14'(v);
        z_valid = 1'b1;
        @(posedge clk); #1;
        z_valid = 1'b0;
    endtask

    task automatic x_pulse(input int v);
        x_data  = 14'(v);
        x_valid = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; z_data = '0; x_data = '0; z_valid = 1'b0; x_valid = 1'b0;
        sen_setting = 2'b00; test = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1. reset state, first sample clears stale
        check("rst_stage", 32'(stage_out), 32'h0);
        check("rst_tip", 32'(tipover), 32'h0);
        check("rst_stale", 32'(stale), 32'h1);
        z_pulse(0);
        check("first_stale", 32'(stale), 32'h0);
        check("first_stage", 32'(stage_out), 32'h0);

        // 2. interrupted run does not rise; three in a row does
        z_pulse(1100); z_pulse(1100); z_pulse(500);
        check("interrupt_stage", 32'(stage_out), 32'h0);
        z_pulse(1100); z_pulse(1100);
        check("two_of_three", 32'(stage_out), 32'h0);
        z_pulse(1100);
        check("rise_01", 32'(stage_out), 32'h1);
        check("rise_any", 32'(any_active), 32'h1);

        // 3. rise to 11, then hold before a one-step drop
        z_pulse(2000); z_pulse(2000); z_pulse(2000);
        check("rise_11", 32'(stage_out), 32'h3);
        repeat (HOLD) z_pulse(500);
        check("hold_11", 32'(stage_out), 32'h3);
        z_pulse(500);
        check("drop_00", 32'(stage_out), 32'h0);

        // 4. hysteresis at level 01
        z_pulse(1100); z_pulse(1100); z_pulse(1100);
        idle(25);
        check("pre_hyst", 32'(stage_out), 32'h1);
        z_pulse(1000);
        check("hyst_keep", 32'(stage_out), 32'h1);
        z_pulse(980);
        check("hyst_drop", 32'(stage_out), 32'h0);

        // 5. timeout and mode handling
        z_pulse(2000); z_pulse(2000); z_pulse(2000);
        idle(TOUT - 1);
        check("pre_timeout_stage", 32'(stage_out), 32'h3);
        check("pre_timeout_stale", 32'(stale), 32'h0);
        idle(1);
        check("timeout_stage", 32'(stage_out), 32'h0);
        check("timeout_stale", 32'(stale), 32'h1);
        z_pulse(2000); z_pulse(2000); z_pulse(2000);
        check("rebuild_11", 32'(stage_out), 32'h3);
        sen_setting = 2'b11;
        idle(1);
        check("disable_clear", 32'(stage_out), 32'h0);
        z_pulse(2000); z_pulse(2000); z_pulse(2000);
        check("disable_ignore", 32'(stage_out), 32'h0);
        sen_setting = 2'b00;
        idle(1);
        z_pulse(2000); z_pulse(2000); z_pulse(2000);
        check("reenable_11", 32'(stage_out), 32'h3);
        sen_setting = 2'b01;
        idle(1);
        check("sen_change_clear", 32'(stage_out), 32'h0);
        sen_setting = 2'b00;
        idle(1);

        // 6. bypass path
        test = 1'b1;
        z_pulse(2000);
        check("byp_11", 32'(stage_out), 32'h3);
        z_pulse(4000);
        check("byp_maxg", 32'(stage_out), 32'h0);
        z_pulse(-500);
        check("byp_neg", 32'(stage_out), 32'h0);
        z_pulse(1100);
        check("byp_01", 32'(stage_out), 32'h1);
        sen_setting = 2'b10;
        idle(1);
        z_pulse(1025);
        check("byp_high_edge", 32'(stage_out), 32'h3);
        z_pulse(1024);
        check("byp_high_below", 32'(stage_out), 32'h1);
        z_pulse(614);
        check("byp_high_zero", 32'(stage_out), 32'h0);
        test = 1'b0;
        sen_setting = 2'b00;
        idle(1);

        // tipover debounce
        x_pulse(3300); x_pulse(3300);
        check("tip_two", 32'(tipover), 32'h0);
        x_pulse(3300);
        check("tip_set", 32'(tipover), 32'h1);
        x_pulse(100); x_pulse(100);
        check("tip_hold", 32'(tipover), 32'h1);
        x_pulse(100);
        check("tip_clear", 32'(tipover), 32'h0);
        x_pulse(3300); x_pulse(3300); x_pulse(3299); x_pulse(3300); x_pulse(3300);
        check("tip_mixed", 32'(tipover), 32'h0);
        x_pulse(8191);
        check("tip_max_in", 32'(tipover), 32'h1);
        x_pulse(-3300); x_pulse(-3300); x_pulse(-3300);
        check("tip_neg_out", 32'(tipover), 32'h0);

        idle(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
